sata_dev_oob_responder: RTL
===========================

// Module: sata_dev_oob_responder
// PURPOSE
// - Device-side OOB/link-bring-up responder for the faux SATA drive. It is the other end of the host stack's OOB initiator.
// - Answers COMRESET with COMINIT, answers COMWAKE with COMWAKE, then sends D10.2 and ALIGN.
// - Waits for the host to return ALIGN and then SYNC, and raises hd_ready.
// - Sits between the host PHY model wiring and the faux drive's link layer.
// PARAMETERS
// - COMM_PULSE_LEN  16    cycles tx_comm_reset (COMINIT) / tx_comm_wake is held high
// - ALIGN_TIMEOUT   1024  cycles to wait for host ALIGN in SEND_D10 before giving up
// - SYNC_DETECT     3     consecutive rx SYNC primitives required to declare ready
// - MAX_RETRY       3     COMINIT retries (used only with SATA_DEV_OOB_RETRY_EN)
// PORTS
// - clk                 in   1   single clock
// - rst_n               in   1   one clock; reset is asynchronous and active-low
// - comm_reset_detect   in   1   host COMRESET seen on line
// - comm_wake_detect    in   1   host COMWAKE seen on line
// - rx_din              in   32  received dword from host
// - rx_isk              in   4   K-char flags for rx_din
// - rx_is_elec_idle     in   1   host line idle
// - rx_byte_is_aligned  in   1   receiver comma-aligned
// - tx_comm_reset       out  1   device COMINIT pulse request
// - tx_comm_wake        out  1   device COMWAKE pulse request
// - tx_dout             out  32  transmitted dword
// - tx_isk              out  4   K-char flags for tx_dout
// - tx_elec_idle        out  1   drive transmitter idle
// - hd_ready            out  1   link up, device ready for link layer
// - oob_state           out  4   current FSM state (debug)
// BEHAVIOUR
// - Primitives:
//   - ALIGN = 32'h7B4A4ABC, isk 4'b0001
//   - SYNC  = 32'hB5B5957C, isk 4'b0001
//   - D10.2 = 32'h4A4A4A4A, isk 4'b0000
// - A primitive matches only when rx_byte_is_aligned=1 and both rx_din and rx_isk equal the primitive.
// - Reset (async, rst_n=0) sets all outputs and counters:
//   - state IDLE; tx_elec_idle=1; tx_comm_reset=0; tx_comm_wake=0; tx_dout=0; tx_isk=0; hd_ready=0; retry=0.
// - All outputs are registered. Responses appear 1 cycle after the causing input.
// - States (oob_state encoding) and transitions:
//   - IDLE(0): on comm_reset_detect -> WAIT_RST_END.
//   - WAIT_RST_END(1): on comm_reset_detect=0 -> SEND_COMINIT, timer cleared.
//   - SEND_COMINIT(2): tx_comm_reset=1 for exactly COMM_PULSE_LEN cycles -> WAIT_COMWAKE.
//   - WAIT_COMWAKE(3): on comm_wake_detect -> WAIT_WAKE_END.
//   - WAIT_WAKE_END(4): on comm_wake_detect=0 -> SEND_COMWAKE.
//   - SEND_COMWAKE(5): tx_comm_wake=1 for exactly COMM_PULSE_LEN cycles -> SEND_D10, timer cleared.
//   - SEND_D10(6): tx_elec_idle=0; tx D10.2 every cycle.
//     - On ALIGN match -> SEND_ALIGN.
//     - If timer reaches ALIGN_TIMEOUT-1 with no match -> timeout (see CONFIGURATION).
//   - SEND_ALIGN(7): tx ALIGN every cycle. Count consecutive SYNC matches; any non-SYNC clears the count.
//     - When the count reaches SYNC_DETECT -> READY.
//   - READY(8): hd_ready=1; tx SYNC when idle.
//     - hd_ready drops only on comm_reset_detect or reset.
// - tx_elec_idle=1 in states 0-5 and 0 in states 6-8.
// - comm_reset_detect=1 in any state except WAIT_RST_END:
//   - next state WAIT_RST_END; hd_ready, tx_comm_* and counters cleared next cycle; tx_elec_idle=1.
//   - Highest priority, beating a simultaneous comm_wake_detect or primitive match.
// - A comm_wake_detect outside WAIT_COMWAKE is ignored.
// - Counters:
//   - timer width is $clog2(ALIGN_TIMEOUT+1); it saturates and never wraps.
//   - sync count width is $clog2(SYNC_DETECT+1).
// - rx_is_elec_idle=1 while in SEND_ALIGN clears the sync count.
// CONFIGURATION
// - SATA_DEV_OOB_RETRY_EN defined:
//   - SEND_D10 timeout with retry<MAX_RETRY: retry+1, -> SEND_COMINIT.
//   - Timeout with retry==MAX_RETRY -> IDLE.
//   - retry clears on READY or COMRESET.
// - SATA_DEV_OOB_RETRY_EN undefined:
//   - SEND_D10 timeout -> IDLE directly.
//   - No retry counter is synthesized.
// TESTING
// - Normal bring-up:
//   - Stimulus: rst_n low 5 cycles, release; comm_reset_detect 1 for 20 cycles -> tx_comm_reset high exactly 16 cycles.
//   - Stimulus: comm_wake 1 for 20 cycles -> tx_comm_wake high exactly 16 cycles, then tx_dout=4A4A4A4A.
//   - Stimulus: feed 7B4A4ABC/0001 -> tx_dout=7B4A4ABC next cycle.
//   - Stimulus: feed 3x B5B5957C -> hd_ready=1 on 4th cycle.
// - SYNC interrupted: SYNC,SYNC,ALIGN,SYNC,SYNC,SYNC -> hd_ready rises only after the final 3 consecutive SYNCs.
// - Misaligned ALIGN: rx_byte_is_aligned=0 with ALIGN on rx_din -> stays in SEND_D10 (oob_state=6).
// - Timeout:
//   - No ALIGN for 1024 cycles in SEND_D10 without macro -> oob_state=0, tx_elec_idle=1.
//   - With macro -> COMINIT re-sent 3 times, then oob_state=0.
// - COMRESET mid-operation:
//   - Assert comm_reset_detect in READY -> hd_ready=0 and oob_state=1 next cycle, then full re-handshake succeeds.
// - Async reset in SEND_ALIGN -> all outputs at reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/sata_dev_oob_responder_if.sv
// Line-side bundle between the host PHY model and the device OOB responder.
// slave: the responder (consumes detects/rx, drives tx/status); master: the PHY/host side.
interface sata_dev_oob_responder_if;
  logic        comm_reset_detect;
  logic        comm_wake_detect;
  logic [31:0] rx_din;
  logic [3:0]  rx_isk;
  logic        rx_is_elec_idle;
  logic        rx_byte_is_aligned;
  logic        tx_comm_reset;
  logic        tx_comm_wake;
  logic [31:0] tx_dout;
  logic [3:0]  tx_isk;
  logic        tx_elec_idle;
  logic        hd_ready;
  logic [3:0]  oob_state;

  modport slave (
    input  comm_reset_detect, comm_wake_detect, rx_din, rx_isk,
           rx_is_elec_idle, rx_byte_is_aligned,
    output tx_comm_reset, tx_comm_wake, tx_dout, tx_isk, tx_elec_idle,
           hd_ready, oob_state
  );

  modport master (
    output comm_reset_detect, comm_wake_detect, rx_din, rx_isk,
           rx_is_elec_idle, rx_byte_is_aligned,
    input  tx_comm_reset, tx_comm_wake, tx_dout, tx_isk, tx_elec_idle,
           hd_ready, oob_state
  );
endinterface

// File: rtl/sata_dev_oob_responder.sv
// Device OOB responder: COMRESET->COMINIT, COMWAKE->COMWAKE, D10.2 until host ALIGN, ALIGN until SYNC lock.
// Latency: all outputs registered, one cycle after the causing input; no backpressure, rx sampled every cycle.
// Option SATA_DEV_OOB_RETRY_EN: on ALIGN timeout re-send COMINIT up to MAX_RETRY times before idling.
module sata_dev_oob_responder #(
  parameter int COMM_PULSE_LEN = 16,
  parameter int ALIGN_TIMEOUT  = 1024,
  parameter int SYNC_DETECT    = 3
`ifdef SATA_DEV_OOB_RETRY_EN
  ,
  parameter int MAX_RETRY      = 3
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sata_dev_oob_responder_if.slave io
);

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    WAIT_RST_END  = 4'd1,
    SEND_COMINIT  = 4'd2,
    WAIT_COMWAKE  = 4'd3,
    WAIT_WAKE_END = 4'd4,
    SEND_COMWAKE  = 4'd5,
    SEND_D10      = 4'd6,
    SEND_ALIGN    = 4'd7,
    READY         = 4'd8
  } state_t;

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] PRIM_D10   = 32'h4A4A4A4A;
  localparam logic [3:0]  ISK_K0     = 4'b0001;

  localparam int TW = $clog2(ALIGN_TIMEOUT + 1);
  localparam int SW = $clog2(SYNC_DETECT + 1);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(COMM_PULSE_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [SW-1:0] SYNC_LAST    = SW'(SYNC_DETECT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic [SW-1:0] sync_cnt;
  logic          align_match;
  logic          sync_match;

`ifdef SATA_DEV_OOB_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry;
`endif

  assign align_match = io.rx_byte_is_aligned && (io.rx_din == PRIM_ALIGN) && (io.rx_isk == ISK_K0);
  assign sync_match  = io.rx_byte_is_aligned && (io.rx_din == PRIM_SYNC)  && (io.rx_isk == ISK_K0);
  // Saturate rather than wrap so a stuck timer can never re-arm a compare.
  assign timer_inc   = (timer == '1) ? timer : timer + 1'b1;
  assign io.oob_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      sync_cnt         <= '0;
      io.tx_comm_reset <= 1'b0;
      io.tx_comm_wake  <= 1'b0;
      io.tx_dout       <= '0;
      io.tx_isk        <= '0;
      io.tx_elec_idle  <= 1'b1;
      io.hd_ready      <= 1'b0;
`ifdef SATA_DEV_OOB_RETRY_EN
      retry            <= '0;
`endif
    end else if (io.comm_reset_detect) begin
      // COMRESET outranks everything, including a same-cycle wake or primitive match.
      state            <= WAIT_RST_END;
      timer            <= '0;
      sync_cnt         <= '0;
      io.tx_comm_reset <= 1'b0;
      io.tx_comm_wake  <= 1'b0;
      io.tx_dout       <= '0;
      io.tx_isk        <= '0;
      io.tx_elec_idle  <= 1'b1;
      io.hd_ready      <= 1'b0;
`ifdef SATA_DEV_OOB_RETRY_EN
      retry            <= '0;
`endif
    end else begin
      case (state)
        IDLE: state <= IDLE;
        WAIT_RST_END: begin
          state            <= SEND_COMINIT;
          timer            <= '0;
          io.tx_comm_reset <= 1'b1;
        end
        SEND_COMINIT: begin
          if (timer == PULSE_LAST) begin
            state            <= WAIT_COMWAKE;
            timer            <= '0;
            io.tx_comm_reset <= 1'b0;
          end else begin
            timer <= timer_inc;
          end
        end
        WAIT_COMWAKE: begin
          if (io.comm_wake_detect) state <= WAIT_WAKE_END;
        end
        WAIT_WAKE_END: begin
          if (!io.comm_wake_detect) begin
            state           <= SEND_COMWAKE;
            timer           <= '0;
            io.tx_comm_wake <= 1'b1;
          end
        end
        SEND_COMWAKE: begin
          if (timer == PULSE_LAST) begin
            state           <= SEND_D10;
            timer           <= '0;
            io.tx_comm_wake <= 1'b0;
            io.tx_elec_idle <= 1'b0;
            io.tx_dout      <= PRIM_D10;
            io.tx_isk       <= 4'b0000;
          end else begin
            timer <= timer_inc;
          end
        end
        SEND_D10: begin
          if (align_match) begin
            state      <= SEND_ALIGN;
            sync_cnt   <= '0;
            io.tx_dout <= PRIM_ALIGN;
            io.tx_isk  <= ISK_K0;
          end else if (timer == TIMEOUT_LAST) begin
            timer           <= '0;
            io.tx_elec_idle <= 1'b1;
            io.tx_dout      <= '0;
            io.tx_isk       <= '0;
`ifdef SATA_DEV_OOB_RETRY_EN
            if (retry < RETRY_MAX) begin
              retry            <= retry + 1'b1;
              state            <= SEND_COMINIT;
              io.tx_comm_reset <= 1'b1;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end else begin
            timer <= timer_inc;
          end
        end
        SEND_ALIGN: begin
          if (io.rx_is_elec_idle || !sync_match) begin
            sync_cnt <= '0;
          end else if (sync_cnt == SYNC_LAST) begin
            state       <= READY;
            sync_cnt    <= '0;
            io.hd_ready <= 1'b1;
            io.tx_dout  <= PRIM_SYNC;
            io.tx_isk   <= ISK_K0;
`ifdef SATA_DEV_OOB_RETRY_EN
            retry       <= '0;
`endif
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        READY: begin
          io.hd_ready <= 1'b1;
          io.tx_dout  <= PRIM_SYNC;
          io.tx_isk   <= ISK_K0;
        end
        default: begin
          state           <= IDLE;
          timer           <= '0;
          sync_cnt        <= '0;
          io.tx_elec_idle <= 1'b1;
          io.tx_dout      <= '0;
          io.tx_isk       <= '0;
          io.hd_ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule
